acc_controller_p: RTL and testbench

Parametrised multi-cycle control unit for the accumulator CPU. It takes an instruction word from instruction memory through a valid handshake and sequences FETCH, DECODE and EXECUTE. It drives IR, PC, register-file, accumulator-mux and ALU controls, and it latches HALT until reset. Compared with the first-generation controller it adds:
- width-generic operand fields;
- separate zero and carry flags;
- ALU results written back to ACC;
- a sticky halt state and a retire pulse.

---
 rtl/acc_controller_p.sv | 156 +++++++++++++++
 tb/tb_acc_controller_p.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_controller_p.sv
// Multi-cycle FETCH/DECODE/EXECUTE controller for the accumulator CPU.
// Outputs are decoded from state, ir_q and taken_q, and are forced to 0 while reset is low.
module acc_controller_p #(
  parameter int ARG_W = 4,
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ARG_W+3:0] instr,
  input  logic             instr_valid,
  input  logic             zero,
  input  logic             carry,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             sel_pc,
  output logic             load_reg,
  output logic             dump_reg,
  output logic             load_acc,
  output logic             dump_acc,
  output logic [1:0]       sel_acc,
  output logic [ALU_W-1:0] sel_alu,
  output logic [ARG_W-1:0] imm,
  output logic [ARG_W-1:0] reg_num,
  output logic             retire,
  output logic             halted,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_NOR = 4'b0011,
                         OP_LDR = 4'b0100, OP_STR = 4'b0101, OP_JZR = 4'b0110,
                         OP_JZI = 4'b0111, OP_JCR = 4'b1000, OP_JCI = 4'b1010,
                         OP_SHL = 4'b1011, OP_SHR = 4'b1100, OP_LDI = 4'b1101,
                         OP_HLT = 4'b1111;

  state_t           state_q, state_d;
  logic [ARG_W+3:0] ir_q;
  logic             taken_q;
  logic [3:0]       op;
  logic             take_d;

  logic             load_ir_c, inc_pc_c, load_pc_c, sel_pc_c, load_reg_c;
  logic             dump_reg_c, load_acc_c, dump_acc_c, retire_c, halted_c;
  logic [1:0]       sel_acc_c;
  logic [3:0]       alu4;
  logic [ARG_W-1:0] arg_c;

  assign op     = ir_q[ARG_W+3:ARG_W];
  assign take_d = ((op == OP_JZR || op == OP_JZI) && zero) ||
                  ((op == OP_JCR || op == OP_JCI) && carry);

  // Handshake: instr is consumed on the edge where state is FETCH and
  // instr_valid is high; load_ir marks that cycle. There is no ready signal,
  // the source must hold instr_valid low outside FETCH or accept it is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) ir_q <= instr;
      if (state_q == S_DECODE) taken_q <= take_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ir_c  = 1'b0;
    inc_pc_c   = 1'b0;
    load_pc_c  = 1'b0;
    sel_pc_c   = 1'b0;
    load_reg_c = 1'b0;
    dump_reg_c = 1'b0;
    load_acc_c = 1'b0;
    dump_acc_c = 1'b0;
    retire_c   = 1'b0;
    halted_c   = 1'b0;
    sel_acc_c  = 2'b00;
    alu4       = 4'b0000;
    arg_c      = '0;

    // Selects are a pure function of the opcode and are held across DECODE and EXECUTE.
    if (state_q == S_DECODE || state_q == S_EXEC) begin
      arg_c = ir_q[ARG_W-1:0];
      case (op)
        OP_ADD:         sel_acc_c = 2'b10;
        OP_SUB:         begin sel_acc_c = 2'b10; alu4 = 4'b0001; end
        OP_NOR:         begin sel_acc_c = 2'b10; alu4 = 4'b1000; end
        OP_LDR:         sel_acc_c = 2'b01;
        OP_JZI, OP_JCI: sel_pc_c  = 1'b1;
        OP_SHL:         begin sel_acc_c = 2'b10; alu4 = 4'b1101; end
        OP_SHR:         begin sel_acc_c = 2'b10; alu4 = 4'b1100; end
        default:        ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        load_ir_c = instr_valid;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_NOR, OP_LDR: begin
            dump_reg_c = 1'b1; load_acc_c = 1'b1; inc_pc_c = 1'b1;
          end
          OP_STR: begin
            dump_acc_c = 1'b1; load_reg_c = 1'b1; inc_pc_c = 1'b1;
          end
          OP_JZR, OP_JCR: begin
            load_pc_c  = taken_q;
            dump_reg_c = taken_q;
            inc_pc_c   = !taken_q;
          end
          OP_JZI, OP_JCI: begin
            load_pc_c = taken_q;
            inc_pc_c  = !taken_q;
          end
          OP_SHL, OP_SHR, OP_LDI: begin
            load_acc_c = 1'b1; inc_pc_c = 1'b1;
          end
          default: inc_pc_c = 1'b1;
        endcase
      end
      S_HALT: halted_c = 1'b1;
    endcase
  end

  assign load_ir  = reset & load_ir_c;
  assign inc_pc   = reset & inc_pc_c;
  assign load_pc  = reset & load_pc_c;
  assign sel_pc   = reset & sel_pc_c;
  assign load_reg = reset & load_reg_c;
  assign dump_reg = reset & dump_reg_c;
  assign load_acc = reset & load_acc_c;
  assign dump_acc = reset & dump_acc_c;
  assign retire   = reset & retire_c;
  assign halted   = reset & halted_c;
  assign sel_acc  = reset ? sel_acc_c : 2'b00;
  assign sel_alu  = reset ? ALU_W'(alu4) : '0;
  assign imm      = reset ? arg_c : '0;
  assign reg_num  = reset ? arg_c : '0;
  assign state    = state_q;

endmodule

// File: tb/tb_acc_controller_p.sv
// Directed bench for acc_controller_p: one task per scenario, inline checks, pass/total summary.
module tb_acc_controller_p;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid, zero, carry;
  logic       load_ir, inc_pc, load_pc, sel_pc, load_reg, dump_reg, load_acc, dump_acc;
  logic [1:0] sel_acc;
  logic [3:0] sel_alu, imm, reg_num;
  logic       retire, halted;
  logic [1:0] state;

  logic [9:0] instr6;
  logic       valid6;
  logic       load_ir6, inc_pc6, load_pc6, sel_pc6, load_reg6, dump_reg6, load_acc6, dump_acc6;
  logic [1:0] sel_acc6;
  logic [3:0] sel_alu6;
  logic [5:0] imm6, reg_num6;
  logic       retire6, halted6;
  logic [1:0] state6;

  int passed = 0;
  int total  = 0;
  int cyc_n  = 0;

  // strb bits: load_ir inc_pc load_pc sel_pc load_reg dump_reg load_acc dump_acc retire halted
  logic [9:0] strb;
  assign strb = {load_ir, inc_pc, load_pc, sel_pc, load_reg, dump_reg, load_acc, dump_acc, retire, halted};

  acc_controller_p #(.ARG_W(4), .ALU_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .zero(zero), .carry(carry),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .sel_pc(sel_pc), .load_reg(load_reg),
    .dump_reg(dump_reg), .load_acc(load_acc), .dump_acc(dump_acc), .sel_acc(sel_acc),
    .sel_alu(sel_alu), .imm(imm), .reg_num(reg_num), .retire(retire), .halted(halted), .state(state)
  );

  acc_controller_p #(.ARG_W(6), .ALU_W(4)) dut6 (
    .clk(clk), .reset(reset), .instr(instr6), .instr_valid(valid6), .zero(zero), .carry(carry),
    .load_ir(load_ir6), .inc_pc(inc_pc6), .load_pc(load_pc6), .sel_pc(sel_pc6), .load_reg(load_reg6),
    .dump_reg(dump_reg6), .load_acc(load_acc6), .dump_acc(dump_acc6), .sel_acc(sel_acc6),
    .sel_alu(sel_alu6), .imm(imm6), .reg_num(reg_num6), .retire(retire6), .halted(halted6),
    .state(state6)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  // drivers: inputs change at posedge+2, checks happen at posedge+3
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [7:0] w);
    instr = w;
    instr_valid = 1'b1;
    cyc();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; instr = 8'hD7; instr_valid = 1'b1; zero = 1'b0; carry = 1'b0;
    instr6 = '0; valid6 = 1'b0;
    cyc(); cyc(); #1;
    total++; if (strb !== 10'b0) $display("FAIL reset_strobes got %b want %b", strb, 10'b0); else passed++;
    total++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else passed++;
    total++; if ({sel_acc, sel_alu, imm, reg_num} !== 14'b0)
      $display("FAIL reset_selects got %h want 0", {sel_acc, sel_alu, imm, reg_num}); else passed++;
    instr_valid = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_ldi();
    instr = 8'hD7; instr_valid = 1'b1; #1;
    total++; if (strb !== 10'b1000000000) $display("FAIL ldi_fetch got %b want 1000000000", strb); else passed++;
    cyc(); instr_valid = 1'b0; #1;
    total++; if (state !== 2'b01) $display("FAIL ldi_dec_state got %b want 01", state); else passed++;
    total++; if ({strb, imm, sel_acc} !== {10'b0, 4'h7, 2'b00})
      $display("FAIL ldi_dec got %b/%h/%b want 0/7/00", strb, imm, sel_acc); else passed++;
    cyc(); #1;
    total++; if (state !== 2'b10) $display("FAIL ldi_exec_state got %b want 10", state); else passed++;
    total++; if (strb !== 10'b0100001010) $display("FAIL ldi_exec got %b want 0100001010", strb); else passed++;
    cyc(); #1;
    total++; if ({state, strb} !== 12'b0) $display("FAIL ldi_back_to_fetch got %b/%b want 00/0", state, strb); else passed++;
  endtask

  task automatic test_back_to_back();
    int r1, r2;
    fetch(8'h13);
    cyc(); #1;
    r1 = cyc_n;
    total++; if ({reg_num, sel_alu, sel_acc} !== {4'h3, 4'h0, 2'b10})
      $display("FAIL add_sel got %h/%h/%b want 3/0/10", reg_num, sel_alu, sel_acc); else passed++;
    total++; if (strb !== 10'b0100011010) $display("FAIL add_strb got %b want 0100011010", strb); else passed++;
    cyc(); instr = 8'h25; instr_valid = 1'b1; #1;
    total++; if (load_ir !== 1'b1) $display("FAIL b2b_load_ir got %b want 1", load_ir); else passed++;
    cyc(); instr_valid = 1'b0;
    cyc(); #1;
    r2 = cyc_n;
    total++; if ({reg_num, sel_alu, sel_acc} !== {4'h5, 4'h1, 2'b10})
      $display("FAIL sub_sel got %h/%h/%b want 5/1/10", reg_num, sel_alu, sel_acc); else passed++;
    total++; if (strb !== 10'b0100011010) $display("FAIL sub_strb got %b want 0100011010", strb); else passed++;
    total++; if (r2 - r1 !== 3) $display("FAIL retire_spacing got %0d want 3", r2 - r1); else passed++;
    cyc();
  endtask

  task automatic test_jzi();
    fetch(8'h79); zero = 1'b1;
    cyc(); zero = 1'b0; #1;
    total++; if (strb !== 10'b0011000010) $display("FAIL jzi_taken got %b want 0011000010", strb); else passed++;
    total++; if (imm !== 4'h9) $display("FAIL jzi_imm got %h want 9", imm); else passed++;
    cyc();
    fetch(8'h79); zero = 1'b0;
    cyc(); zero = 1'b1; #1;
    total++; if (strb !== 10'b0101000010) $display("FAIL jzi_not_taken got %b want 0101000010", strb); else passed++;
    cyc(); zero = 1'b0;
  endtask

  task automatic test_jcr();
    fetch(8'h82); carry = 1'b1; zero = 1'b0;
    cyc(); #1;
    total++; if (strb !== 10'b0010010010) $display("FAIL jcr_taken got %b want 0010010010", strb); else passed++;
    total++; if (reg_num !== 4'h2) $display("FAIL jcr_reg_num got %h want 2", reg_num); else passed++;
    cyc();
    fetch(8'h82); carry = 1'b0; zero = 1'b1;
    cyc(); #1;
    total++; if (strb !== 10'b0100000010) $display("FAIL jcr_not_taken got %b want 0100000010", strb); else passed++;
    cyc(); zero = 1'b0;
  endtask

  task automatic test_idle();
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      total++; if ({state, load_ir} !== 3'b000) $display("FAIL idle_%0d got %b/%b want 00/0", i, state, load_ir); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    fetch(8'h54);
    cyc(); #1;
    total++; if (strb !== 10'b0100100110) $display("FAIL str_exec got %b want 0100100110", strb); else passed++;
    reset = 1'b0; #1;
    total++; if ({state, strb} !== 12'b0) $display("FAIL str_reset got %b/%b want 00/0", state, strb); else passed++;
    cyc(); reset = 1'b1; #1;
    total++; if ({state, strb} !== 12'b0) $display("FAIL post_reset got %b/%b want 00/0", state, strb); else passed++;
    fetch(8'hD2);
    #1;
    total++; if (imm !== 4'h2) $display("FAIL post_reset_imm got %h want 2", imm); else passed++;
    cyc(); cyc();
  endtask

  task automatic test_halt();
    int bad;
    bad = 0;
    fetch(8'hF0); #1;
    total++; if ({state, strb} !== {2'b01, 10'b0}) $display("FAIL halt_decode got %b/%b want 01/0", state, strb); else passed++;
    instr = 8'hD7; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      if ({state, strb} !== {2'b11, 10'b0000000001}) bad++;
    end
    total++; if (bad !== 0) $display("FAIL halt_hold got %0d bad cycles want 0", bad); else passed++;
    reset = 1'b0; #1;
    total++; if ({state, strb} !== 12'b0) $display("FAIL halt_reset got %b/%b want 00/0", state, strb); else passed++;
    instr_valid = 1'b0;
    cyc(); reset = 1'b1; #1;
    total++; if (state !== 2'b00) $display("FAIL halt_exit got %b want 00", state); else passed++;
  endtask

  task automatic test_argw6();
    instr6 = 10'b1101_111111; valid6 = 1'b1;
    cyc(); valid6 = 1'b0; #1;
    total++; if ({state6, imm6, reg_num6} !== {2'b01, 6'h3F, 6'h3F})
      $display("FAIL w6_decode got %b/%h/%h want 01/3f/3f", state6, imm6, reg_num6); else passed++;
    cyc(); #1;
    total++; if ({load_acc6, inc_pc6, retire6, sel_acc6} !== 5'b11100)
      $display("FAIL w6_exec got %b want 11100", {load_acc6, inc_pc6, retire6, sel_acc6}); else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_back_to_back();
    test_jzi();
    test_jcr();
    test_idle();
    test_reset_mid();
    test_halt();
    test_argw6();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
